// File: rtl/cpu_ifetch_prefetch_if.sv
// Cache-miss and instruction-bus signals of the sequential prefetcher.
// The slave view is the prefetcher; the master view is the cache plus bus environment.
interface cpu_ifetch_prefetch_if;
  logic        i_request;
  logic        o_ready;
  logic [31:0] i_address;
  logic [31:0] o_rdata;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;

  modport slave (
    input  i_request, i_address, i_bus_ready, i_bus_rdata,
    output o_ready, o_rdata, o_bus_request, o_bus_address
  );

  modport master (
    output i_request, i_address, i_bus_ready, i_bus_rdata,
    input  o_ready, o_rdata, o_bus_request, o_bus_address
  );
endinterface

// File: rtl/cpu_ifetch_prefetch.sv
// Single-word sequential instruction prefetcher: serves I-cache misses from a one-entry
// buffer or a demand bus read, then speculatively fetches the next sequential word.
module cpu_ifetch_prefetch #(
  parameter logic [31:0] STRIDE      = 32'd4,
  parameter bit          SPEC_ENABLE = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  cpu_ifetch_prefetch_if.slave  pf_if,
  output logic [31:0]           o_buf_hit_count,
  output logic [31:0]           o_buf_miss_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEMAND = 2'd1,
    DONE   = 2'd2,
    SPEC   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] spec_addr_q, spec_addr_d;
  logic        spec_pending_q, spec_pending_d;
  logic        spec_discard_q, spec_discard_d;
  logic [31:0] served_addr_q, served_addr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic buf_hit_s;
  logic demand_go_s;
  logic spec_go_s;

  // A flushed buffer never hits; no bus read is launched while the bus still shows ready.
  assign buf_hit_s   = pf_if.i_request & buf_valid_q & (buf_addr_q == pf_if.i_address) & ~i_flush;
  assign demand_go_s = pf_if.i_request & ~buf_hit_s & ~pf_if.i_bus_ready;
  assign spec_go_s   = ~pf_if.i_request & spec_pending_q & SPEC_ENABLE & ~pf_if.i_bus_ready & ~i_flush;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (buf_hit_s)        state_d = DONE;
        else if (demand_go_s) state_d = DEMAND;
        else if (spec_go_s)   state_d = SPEC;
        else                  state_d = IDLE;
      end
      DEMAND:  state_d = pf_if.i_bus_ready ? DONE : DEMAND;
      DONE:    state_d = pf_if.i_request ? DONE : IDLE;
      SPEC:    state_d = pf_if.i_bus_ready ? IDLE : SPEC;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    ready_d        = ready_q;
    rdata_d        = rdata_q;
    bus_req_d      = bus_req_q;
    bus_addr_d     = bus_addr_q;
    buf_addr_d     = buf_addr_q;
    buf_data_d     = buf_data_q;
    buf_valid_d    = buf_valid_q;
    spec_addr_d    = spec_addr_q;
    spec_pending_d = spec_pending_q;
    spec_discard_d = spec_discard_q;
    served_addr_d  = served_addr_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (buf_hit_s) begin
          rdata_d       = buf_data_q;
          ready_d       = 1'b1;
          hit_cnt_d     = hit_cnt_q + 32'd1;
          buf_valid_d   = 1'b0;
          served_addr_d = pf_if.i_address;
        end else if (demand_go_s) begin
          miss_cnt_d     = miss_cnt_q + 32'd1;
          bus_addr_d     = pf_if.i_address;
          bus_req_d      = 1'b1;
          served_addr_d  = pf_if.i_address;
          spec_pending_d = 1'b0;
        end else if (spec_go_s) begin
          bus_addr_d     = spec_addr_q;
          bus_req_d      = 1'b1;
          spec_discard_d = 1'b0;
        end else begin
        end
      end
      DEMAND: begin
        if (pf_if.i_bus_ready) begin
          rdata_d   = pf_if.i_bus_rdata;
          ready_d   = 1'b1;
          bus_req_d = 1'b0;
        end else begin
        end
      end
      DONE: begin
        if (!pf_if.i_request) begin
          ready_d        = 1'b0;
          spec_addr_d    = served_addr_q + STRIDE;
          spec_pending_d = SPEC_ENABLE;
        end else begin
        end
      end
      SPEC: begin
        if (pf_if.i_bus_ready) begin
          buf_addr_d     = bus_addr_q;
          buf_data_d     = pf_if.i_bus_rdata;
          buf_valid_d    = ~spec_discard_q;
          spec_pending_d = 1'b0;
          bus_req_d      = 1'b0;
        end else begin
        end
      end
      default: begin
        ready_d   = 1'b0;
        bus_req_d = 1'b0;
      end
    endcase
    // Flush wins over any same-cycle buffer load and poisons an in-flight speculative read.
    buf_valid_d    = buf_valid_d & ~i_flush;
    spec_pending_d = spec_pending_d & ~i_flush;
    spec_discard_d = spec_discard_d | (i_flush & (state_q == SPEC));
  end

  // Datapath and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q        <= 1'b0;
      rdata_q        <= 32'd0;
      bus_req_q      <= 1'b0;
      bus_addr_q     <= 32'd0;
      buf_addr_q     <= 32'd0;
      buf_data_q     <= 32'd0;
      buf_valid_q    <= 1'b0;
      spec_addr_q    <= 32'd0;
      spec_pending_q <= 1'b0;
      spec_discard_q <= 1'b0;
      served_addr_q  <= 32'd0;
      hit_cnt_q      <= 32'd0;
      miss_cnt_q     <= 32'd0;
    end else begin
      ready_q        <= ready_d;
      rdata_q        <= rdata_d;
      bus_req_q      <= bus_req_d;
      bus_addr_q     <= bus_addr_d;
      buf_addr_q     <= buf_addr_d;
      buf_data_q     <= buf_data_d;
      buf_valid_q    <= buf_valid_d;
      spec_addr_q    <= spec_addr_d;
      spec_pending_q <= spec_pending_d;
      spec_discard_q <= spec_discard_d;
      served_addr_q  <= served_addr_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign pf_if.o_ready       = ready_q;
  assign pf_if.o_rdata       = rdata_q;
  assign pf_if.o_bus_request = bus_req_q;
  assign pf_if.o_bus_address = bus_addr_q;
  assign o_buf_hit_count     = hit_cnt_q;
  assign o_buf_miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_cpu_ifetch_prefetch.sv
// Directed bench for cpu_ifetch_prefetch: a scoreboard of expected words and a log of
// bus read addresses, checked with immediate assertions.
module tb_cpu_ifetch_prefetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          bus_lat  = 2;
  int          wait_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] bus_log[$];

  cpu_ifetch_prefetch_if pf_if ();

  cpu_ifetch_prefetch #(.STRIDE(32'd4), .SPEC_ENABLE(1'b1)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_flush          (flush),
    .pf_if            (pf_if),
    .o_buf_hit_count  (hit_cnt),
    .o_buf_miss_count (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA_0001;
      32'h0000_0104: return 32'h0000_0013;
      default:       return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] exp);
    logic [31:0] a;
    if (bus_log.size() > 0) a = bus_log.pop_front();
    else                    a = 32'hDEAD_BEEF;
    chk(tag, a, exp);
  endtask

  // Issue one cache request, wait (bounded) for o_ready, compare against the scoreboard, release it.
  task automatic do_req(input string tag, input logic [31:0] addr, output int lat);
    bit          got;
    logic [31:0] exp;
    sb_q.push_back(mem_rd(addr));
    @(posedge clk); #1;
    pf_if.i_request = 1'b1;
    pf_if.i_address = addr;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (pf_if.o_ready) got = 1'b1;
    end
    chk({tag, " ready"}, {31'd0, got}, 32'd1);
    exp = sb_q.pop_front();
    if (got) chk({tag, " rdata"}, pf_if.o_rdata, exp);
    @(posedge clk); #1;
    pf_if.i_request = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " ready drop"}, {31'd0, pf_if.o_ready}, 32'd0);
  endtask

  task automatic wait_bus_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pf_if.o_bus_request) seen = 1'b1;
    end
    chk({tag, " bus req"}, {31'd0, seen}, 32'd1);
  endtask

  // Bus slave: answers each read after bus_lat idle cycles with a one-cycle ready pulse.
  initial begin
    pf_if.i_bus_ready = 1'b0;
    pf_if.i_bus_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        pf_if.i_bus_ready = 1'b0;
        wait_cnt = 0;
      end else if (pf_if.i_bus_ready) begin
        pf_if.i_bus_ready = 1'b0;
      end else if (pf_if.o_bus_request) begin
        if (wait_cnt >= bus_lat) begin
          pf_if.i_bus_ready = 1'b1;
          pf_if.i_bus_rdata = mem_rd(pf_if.o_bus_address);
          bus_log.push_back(pf_if.o_bus_address);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    flush = 1'b0;
    pf_if.i_request = 1'b0;
    pf_if.i_address = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, pf_if.o_ready}, 32'd0);
    chk("reset bus req", {31'd0, pf_if.o_bus_request}, 32'd0);
    chk("reset rdata", pf_if.o_rdata, 32'd0);
    chk("reset hits", hit_cnt, 32'd0);
    chk("reset misses", miss_cnt, 32'd0);
    rst_n = 1'b1;

    // 1: cold miss, then a speculative read of the next word
    bus_lat = 2;
    do_req("t1", 32'h0000_0100, lat);
    chk("t1 misses", miss_cnt, 32'd1);
    chk("t1 hits", hit_cnt, 32'd0);
    repeat (10) @(posedge clk);
    chk_bus("t1 demand addr", 32'h0000_0100);
    chk_bus("t1 spec addr", 32'h0000_0104);

    // 2: sequential request served from the buffer in one cycle
    do_req("t2", 32'h0000_0104, lat);
    chk("t2 latency", lat, 32'd1);
    chk("t2 hits", hit_cnt, 32'd1);
    chk("t2 no bus", bus_log.size(), 32'd0);
    bus_lat = 4;

    // 3: non-sequential request while the spec read of 0x108 is in flight
    wait_bus_req("t3");
    chk("t3 spec addr live", pf_if.o_bus_address, 32'h0000_0108);
    do_req("t3", 32'h0000_0200, lat);
    chk("t3 misses", miss_cnt, 32'd2);
    chk("t3 hits", hit_cnt, 32'd1);
    chk_bus("t3 spec addr", 32'h0000_0108);
    chk_bus("t3 demand addr", 32'h0000_0200);

    // 4: flush during a speculative read, then ask for the flushed address
    wait_bus_req("t4");
    chk("t4 spec addr live", pf_if.o_bus_address, 32'h0000_0204);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (8) @(posedge clk);
    do_req("t4", 32'h0000_0204, lat);
    chk("t4 misses", miss_cnt, 32'd3);
    chk("t4 hits", hit_cnt, 32'd1);
    repeat (12) @(posedge clk);
    chk_bus("t4 spec addr", 32'h0000_0204);
    chk_bus("t4 demand addr", 32'h0000_0204);
    chk_bus("t4 next spec", 32'h0000_0208);

    // 5: top-of-memory request; the speculative address wraps to zero
    bus_lat = 1;
    do_req("t5", 32'hFFFF_FFFC, lat);
    chk("t5 misses", miss_cnt, 32'd4);
    repeat (8) @(posedge clk);
    chk_bus("t5 demand addr", 32'hFFFF_FFFC);
    chk_bus("t5 wrap spec", 32'h0000_0000);
    do_req("t5 wrap", 32'h0000_0000, lat);
    chk("t5 latency", lat, 32'd1);
    chk("t5 hits", hit_cnt, 32'd2);
    repeat (8) @(posedge clk);
    chk_bus("t5 after-hit spec", 32'h0000_0004);

    // 6: load 0x40 into the buffer, reset mid-demand, then request 0x40
    do_req("t6 prep", 32'h0000_003C, lat);
    chk("t6 prep misses", miss_cnt, 32'd5);
    repeat (8) @(posedge clk);
    chk_bus("t6 prep demand", 32'h0000_003C);
    chk_bus("t6 prep spec", 32'h0000_0040);
    bus_lat = 6;
    @(posedge clk); #1;
    pf_if.i_request = 1'b1;
    pf_if.i_address = 32'h0000_0080;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6 in demand", {31'd0, pf_if.o_bus_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 reset bus req", {31'd0, pf_if.o_bus_request}, 32'd0);
    chk("t6 reset bus addr", pf_if.o_bus_address, 32'd0);
    chk("t6 reset rdata", pf_if.o_rdata, 32'd0);
    chk("t6 reset hits", hit_cnt, 32'd0);
    chk("t6 reset misses", miss_cnt, 32'd0);
    pf_if.i_request = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6 no stale bus", bus_log.size(), 32'd0);
    bus_lat = 2;
    do_req("t6", 32'h0000_0040, lat);
    chk("t6 misses", miss_cnt, 32'd1);
    chk("t6 hits", hit_cnt, 32'd0);
    chk_bus("t6 demand addr", 32'h0000_0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
